// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader: FSM states, error codes
// and a width helper.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames bytes into instruction words, writes them
// to program memory and holds the CPU in reset while a load is in flight.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH     = 24,
  parameter int unsigned ADDR_BITS      = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [1:0]            err
);

  localparam int unsigned BPW    = WORD_WIDTH / 8;
  localparam int unsigned BCNT_W = clog2_min1(BPW);
  localparam int unsigned WCNT_W = ((ADDR_BITS > 8) ? ADDR_BITS : 8) + 1;
  localparam int unsigned TMO_W  = clog2_min1(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, mem_addr_d;
  logic [WORD_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [7:0]            csum_q, csum_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [BCNT_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0]     words_left_q, words_left_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic accept;
  logic in_frame;
  logic expire;

  assign accept   = in_valid && in_ready_q;
  assign in_frame = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  // A byte landing on the expiry cycle wins over the timeout.
  assign expire   = in_frame && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_we_q ? mem_addr_q + ADDR_BITS'(1) : mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    done_d       = 1'b0;
    err_d        = err_q;
    csum_d       = csum_q;
    word_d       = word_q;
    byte_cnt_d   = byte_cnt_q;
    words_left_d = words_left_q;
    tmo_d        = (accept || !in_frame) ? '0 : tmo_q + TMO_W'(1);

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d    = S_COUNT;
          cpu_hold_d = 1'b1;
          err_d      = ERR_NONE;
          mem_addr_d = '0;
          csum_d     = '0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          csum_d       = csum_q ^ in_data;
          words_left_d = (in_data == 8'd0) ? WCNT_W'(2 ** ADDR_BITS) : WCNT_W'(in_data);
          byte_cnt_d   = '0;
          state_d      = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          word_d = (word_q << 8) | WORD_WIDTH'(in_data);
          if (byte_cnt_q == BCNT_W'(BPW - 1)) begin
            byte_cnt_d   = '0;
            mem_we_d     = 1'b1;
            mem_wdata_d  = word_d;
            words_left_d = words_left_q - WCNT_W'(1);
            if (words_left_q == WCNT_W'(1)) begin
              state_d = S_CHECK;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (in_data == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = ERR_CSUM;
          end
        end
      end
      S_DONE: begin
        cpu_hold_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) begin
      state_d = S_ERROR;
      err_d   = ERR_TIMEOUT;
    end

    in_ready_d = (state_d != S_DONE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      in_ready_q   <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= ERR_NONE;
      csum_q       <= '0;
      word_q       <= '0;
      byte_cnt_q   <= '0;
      words_left_q <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      byte_cnt_q   <= byte_cnt_d;
      words_left_q <= words_left_d;
      tmo_q        <= tmo_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level reference model compared
// every cycle, plus hand-computed expectations for each directed scenario.
module tb_prog_loader;

  localparam int unsigned AB  = 3;
  localparam int unsigned TMO = 16;

  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_DONE  = 2;
  localparam int M_ERR   = 3;

  logic          clk_in   = 1'b0;
  logic          rst_in   = 1'b1;
  logic [7:0]    in_data  = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AB-1:0] mem_addr;
  logic [23:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic [1:0]    err;

  prog_loader #(
    .WORD_WIDTH    (24),
    .ADDR_BITS     (AB),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame position decides the meaning of each byte.
  int            m_mode = M_IDLE;
  int            m_pos  = 0;
  int            m_n    = 0;
  int            m_idle = 0;
  logic [7:0]    m_csum = 8'h00;
  logic [23:0]   m_acc  = 24'h0;
  logic          e_ready = 1'b1;
  logic          e_we    = 1'b0;
  logic [AB-1:0] e_addr  = '0;
  logic [23:0]   e_wdata = 24'h0;
  logic          e_hold  = 1'b0;
  logic          e_done  = 1'b0;
  logic [1:0]    e_err   = 2'b00;

  logic [26:0] wr_log[$];
  int          done_cnt = 0;

  always @(negedge clk_in) begin : cmp
    logic take;
    logic bump;
    if (rst_in) begin
      m_mode = M_IDLE; m_pos = 0; m_idle = 0; m_csum = 8'h00;
      e_ready = 1'b1; e_we = 1'b0; e_addr = '0; e_wdata = 24'h0;
      e_hold = 1'b0; e_done = 1'b0; e_err = 2'b00;
    end
    check("in_ready",  32'(in_ready),  32'(e_ready));
    check("mem_we",    32'(mem_we),    32'(e_we));
    check("mem_addr",  32'(mem_addr),  32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    check("cpu_hold",  32'(cpu_hold),  32'(e_hold));
    check("done",      32'(done),      32'(e_done));
    check("err",       32'(err),       32'(e_err));
    if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
    if (done) done_cnt++;
    if (!rst_in) begin
      take = in_valid && e_ready;
      bump = e_we;
      e_we = 1'b0;
      e_done = 1'b0;
      if (bump) e_addr = e_addr + 1'b1;
      case (m_mode)
        M_IDLE, M_ERR: begin
          if (take && in_data == 8'hA5) begin
            m_mode = M_FRAME; m_pos = 0; m_idle = 0; m_csum = 8'h00;
            e_hold = 1'b1; e_err = 2'b00; e_addr = '0;
          end
        end
        M_FRAME: begin
          if (take) begin
            m_idle = 0;
            if (m_pos == 0) begin
              m_n = (in_data == 8'h00) ? (1 << AB) : int'(in_data);
              m_csum = m_csum ^ in_data;
            end else if (m_pos <= 3 * m_n) begin
              m_csum = m_csum ^ in_data;
              m_acc  = {m_acc[15:0], in_data};
              if (m_pos % 3 == 0) begin
                e_we = 1'b1;
                e_wdata = m_acc;
              end
            end else if (in_data == m_csum) begin
              m_mode = M_DONE;
              e_done = 1'b1;
            end else begin
              m_mode = M_ERR;
              e_err = 2'b01;
            end
            m_pos++;
          end else begin
            m_idle++;
            if (m_idle == TMO) begin
              m_mode = M_ERR;
              e_err = 2'b10;
            end
          end
        end
        M_DONE: begin
          m_mode = M_IDLE;
          e_hold = 1'b0;
        end
        default: m_mode = M_IDLE;
      endcase
      e_ready = (m_mode != M_DONE);
    end
  end

  function automatic logic [7:0] xsum(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x = x ^ q[i];
    return x;
  endfunction

  task automatic put_byte(input logic [7:0] b);
    logic r;
    int guard = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      r = in_ready;
      @(posedge clk_in); #1;
      guard++;
    end while (!r && guard < 8);
    if (!r) check("ready_wait", 32'(r), 32'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic send(input logic [7:0] q[$]);
    foreach (q[i]) put_byte(q[i]);
    in_valid = 1'b0;
  endtask

  logic [7:0]  q[$];
  logic [7:0]  body[$];
  logic [23:0] w;
  int          d0;

  initial begin
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_hold",     32'(cpu_hold), 32'(0));
    check("rst_err",      32'(err),      32'(0));
    rst_in = 1'b0;
    idle(2);

    // Frame with one word
    body = {8'h01, 8'h12, 8'h34, 8'h56};
    check("model_csum", 32'(xsum(body)), 32'h71);
    wr_log.delete(); d0 = done_cnt;
    send({8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h71});
    idle(3);
    check("t1_nwr",  32'(wr_log.size()), 32'(1));
    if (wr_log.size() > 0) check("t1_wr", 32'(wr_log[0]), 32'({3'd0, 24'h123456}));
    check("t1_done", 32'(done_cnt - d0), 32'(1));
    check("t1_hold", 32'(cpu_hold), 32'(0));

    // Three words, valid held high throughout
    body = {8'h03};
    for (int i = 0; i < 9; i++) body.push_back(8'(8'h10 + 8'(i * 17)));
    q = {8'hA5};
    foreach (body[i]) q.push_back(body[i]);
    q.push_back(xsum(body));
    wr_log.delete(); d0 = done_cnt;
    send(q);
    idle(3);
    check("t2_nwr", 32'(wr_log.size()), 32'(3));
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      w = {body[1 + 3*i], body[2 + 3*i], body[3 + 3*i]};
      check("t2_wr", 32'(wr_log[i]), 32'({3'(i), w}));
    end
    check("t2_done", 32'(done_cnt - d0), 32'(1));
    check("t2_err",  32'(err), 32'(0));

    // Bad check byte, then recovery
    d0 = done_cnt;
    send({8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h72});
    idle(3);
    check("t3_err",  32'(err), 32'(1));
    check("t3_hold", 32'(cpu_hold), 32'(1));
    check("t3_done", 32'(done_cnt - d0), 32'(0));
    send({8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h71});
    idle(3);
    check("t3_err_clr", 32'(err), 32'(0));
    check("t3_done2",   32'(done_cnt - d0), 32'(1));

    // Stall after second data byte until timeout
    put_byte(8'hA5); put_byte(8'h01); put_byte(8'h12); put_byte(8'h34);
    in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_in); #1;
      if (k == 15) check("t4_err_c15", 32'(err), 32'(0));
      if (k == 16) check("t4_err_c16", 32'(err), 32'(2));
    end
    check("t4_hold", 32'(cpu_hold), 32'(1));
    d0 = done_cnt;
    put_byte(8'hA5); put_byte(8'h01); put_byte(8'h12); put_byte(8'h34);
    idle(14);
    put_byte(8'h56); put_byte(8'h71);
    in_valid = 1'b0;
    idle(3);
    check("t4_noerr", 32'(err), 32'(0));
    check("t4_done",  32'(done_cnt - d0), 32'(1));

    // Garbage in idle, then N=0 -> full 8-word memory
    wr_log.delete();
    send({8'h00, 8'hFF});
    idle(2);
    check("t5_garbage_nwr", 32'(wr_log.size()), 32'(0));
    check("t5_garbage_hold", 32'(cpu_hold), 32'(0));
    body = {8'h00};
    for (int i = 0; i < 24; i++) body.push_back(8'(i * 37 + 5));
    q = {8'hA5};
    foreach (body[i]) q.push_back(body[i]);
    q.push_back(xsum(body));
    d0 = done_cnt;
    send(q);
    idle(3);
    check("t5_nwr", 32'(wr_log.size()), 32'(8));
    for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
      w = {body[1 + 3*i], body[2 + 3*i], body[3 + 3*i]};
      check("t5_wr", 32'(wr_log[i]), 32'({3'(i), w}));
    end
    check("t5_done", 32'(done_cnt - d0), 32'(1));

    // Asynchronous reset in the middle of DATA
    put_byte(8'hA5); put_byte(8'h03); put_byte(8'h11); put_byte(8'h22);
    put_byte(8'h33); put_byte(8'h44);
    in_valid = 1'b0;
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    #1;
    check("t6_ready", 32'(in_ready),  32'(1));
    check("t6_we",    32'(mem_we),    32'(0));
    check("t6_addr",  32'(mem_addr),  32'(0));
    check("t6_wdata", 32'(mem_wdata), 32'(0));
    check("t6_hold",  32'(cpu_hold),  32'(0));
    check("t6_done",  32'(done),      32'(0));
    check("t6_err",   32'(err),       32'(0));
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle(1);
    wr_log.delete(); d0 = done_cnt;
    body = {8'h01, 8'hAB, 8'hCD, 8'hEF};
    send({8'hA5, 8'h01, 8'hAB, 8'hCD, 8'hEF, xsum(body)});
    idle(3);
    check("t6_nwr", 32'(wr_log.size()), 32'(1));
    if (wr_log.size() > 0) check("t6_wr", 32'(wr_log[0]), 32'({3'd0, 24'hABCDEF}));
    check("t6_done2", 32'(done_cnt - d0), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
